// File: rtl/il_pingpong_ctrl.sv
// Address and handshake controller for a two-bank ping-pong block interleaver.
// One bank is filled row-major while the other, full bank is read out in permuted order.
module il_pingpong_ctrl #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4,
    parameter int unsigned MODE = 0,
    parameter int unsigned AW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic          wr_zero,
    output logic          rd_en,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [1:0]    bank_full
);
    localparam int unsigned   N    = ROWS * COLS;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic {W_DATA, W_PAD} wstate_e;

    wstate_e       wstate;
    wstate_e       wstate_nxt;
    logic          run;
    logic [AW-1:0] j;
    logic [AW-1:0] k;
    logic          padding;
    logic          accept;
    logic          wr_done;
    logic          rd_done;
    logic          flush_go;
    logic [1:0]    full_nxt;

    // Write-side state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate <= W_DATA;
        end else begin
            wstate <= wstate_nxt;
        end
    end

    // Write-side next state: enter padding on a valid flush, leave on the block's last write
    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_DATA:  if (flush_go) wstate_nxt = W_PAD;
            W_PAD:   if (wr_done)  wstate_nxt = W_DATA;
            default: wstate_nxt = W_DATA;
        endcase
    end

    // Write-side outputs; flush only counts for a partial block not being completed this cycle
    always_comb begin
        padding  = (wstate == W_PAD);
        in_ready = run && !bank_full[wr_bank] && !padding;
        accept   = in_valid && in_ready;
        wr_en    = accept || padding;
        wr_zero  = padding;
        wr_addr  = j;
        wr_done  = wr_en && (j == LAST);
        flush_go = flush && !padding && (j != '0) && !wr_done;
    end

    // Read side issue and bank occupancy; the two banks never update the same flag in one cycle
    always_comb begin
        rd_en    = bank_full[rd_bank] && (!out_valid || out_ready);
        rd_done  = rd_en && (k == LAST);
        full_nxt = bank_full;
        if (wr_done) full_nxt[wr_bank] = 1'b1;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
    end

    // Permuted read address: column-wise walk of the row-major matrix (or its transpose)
    always_comb begin
        if (MODE == 0) begin
            rd_addr = AW'((32'(k) % ROWS) * COLS + 32'(k) / ROWS);
        end else begin
            rd_addr = AW'((32'(k) % COLS) * ROWS + 32'(k) / COLS);
        end
    end

    // Counters, bank pointers and occupancy; run keeps in_ready low until the first clock out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run       <= 1'b0;
            j         <= '0;
            k         <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= '0;
        end else begin
            run       <= 1'b1;
            bank_full <= full_nxt;
            if (wr_en) begin
                j <= wr_done ? '0 : j + AW'(1);
                if (wr_done) wr_bank <= ~wr_bank;
            end
            if (rd_en) begin
                k <= rd_done ? '0 : k + AW'(1);
                if (rd_done) rd_bank <= ~rd_bank;
            end
        end
    end

    // Output qualifiers track the RAM's one-cycle read latency and hold under backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (rd_en) begin
            out_valid <= 1'b1;
            out_last  <= rd_done;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_il_pingpong_ctrl.sv
// Directed bench for il_pingpong_ctrl: an interleaver and a deinterleaver instance,
// each paired with a behavioural two-bank RAM that carries 8-bit symbol tags.
module tb_il_pingpong_ctrl;
    localparam int AW  = 4;
    localparam int N   = 16;
    localparam int LOG = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic          flush     [2];
    logic          wr_en     [2];
    logic          wr_bank   [2];
    logic [AW-1:0] wr_addr   [2];
    logic          wr_zero   [2];
    logic          rd_en     [2];
    logic          rd_bank   [2];
    logic [AW-1:0] rd_addr   [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic          out_last  [2];
    logic [1:0]    bank_full [2];
    logic [7:0]    din       [2];

    always #5 clk = ~clk;

    il_pingpong_ctrl #(.ROWS(4), .COLS(4), .MODE(0), .AW(AW)) u_il (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .flush(flush[0]),
        .wr_en(wr_en[0]), .wr_bank(wr_bank[0]), .wr_addr(wr_addr[0]), .wr_zero(wr_zero[0]),
        .rd_en(rd_en[0]), .rd_bank(rd_bank[0]), .rd_addr(rd_addr[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_last(out_last[0]), .bank_full(bank_full[0])
    );

    il_pingpong_ctrl #(.ROWS(4), .COLS(4), .MODE(1), .AW(AW)) u_dil (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .flush(flush[1]),
        .wr_en(wr_en[1]), .wr_bank(wr_bank[1]), .wr_addr(wr_addr[1]), .wr_zero(wr_zero[1]),
        .rd_en(rd_en[1]), .rd_bank(rd_bank[1]), .rd_addr(rd_addr[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_last(out_last[1]), .bank_full(bank_full[1])
    );

    // RAM model and event logs, evaluated mid-cycle while inputs and outputs are stable
    logic [7:0]    mem      [2][2][N];
    logic [7:0]    rd_data  [2];
    logic [7:0]    out_data [2][LOG];
    logic          out_lst  [2][LOG];
    int            out_cnt  [2] = '{0, 0};
    logic [AW-1:0] rd_log   [2][LOG];
    int            rd_cnt   [2] = '{0, 0};
    logic [AW-1:0] wr_log   [LOG];
    logic          wz_log   [LOG];
    int            wr_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                if (out_valid[u] && out_ready[u] && out_cnt[u] < LOG) begin
                    out_data[u][out_cnt[u]] = rd_data[u];
                    out_lst[u][out_cnt[u]]  = out_last[u];
                    out_cnt[u] = out_cnt[u] + 1;
                end
                if (rd_en[u]) begin
                    rd_data[u] = mem[u][rd_bank[u]][rd_addr[u]];
                    if (rd_cnt[u] < LOG) begin
                        rd_log[u][rd_cnt[u]] = rd_addr[u];
                        rd_cnt[u] = rd_cnt[u] + 1;
                    end
                end
                if (wr_en[u]) mem[u][wr_bank[u]][wr_addr[u]] = wr_zero[u] ? 8'd0 : din[u];
            end
            if (wr_en[0] && wr_cnt < LOG) begin
                wr_log[wr_cnt] = wr_addr[0];
                wz_log[wr_cnt] = wr_zero[0];
                wr_cnt = wr_cnt + 1;
            end
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] perm [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
        logic [7:0] exp_d;
        int c, sent, drops, first_acc, first_ov, ovs;
        int b_out, b_rd, b_wr, b_out1;

        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0; flush[u] = 1'b0; out_ready[u] = 1'b1; din[u] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs_il", {in_ready[0], wr_en[0], wr_bank[0], wr_addr[0], wr_zero[0], rd_en[0],
            rd_bank[0], rd_addr[0], out_valid[0], out_last[0], bank_full[0]}, 0);
        chk("reset_outputs_dil", {in_ready[1], wr_en[1], wr_bank[1], wr_addr[1], wr_zero[1], rd_en[1],
            rd_bank[1], rd_addr[1], out_valid[1], out_last[1], bank_full[1]}, 0);
        rst = 1'b1;
        tick(); tick();
        #1;
        chk("ready_after_reset", in_ready[0], 1);

        // 32 symbols at full rate through the interleaver
        c = 0; sent = 0; drops = 0; first_acc = -1; first_ov = -1;
        b_out = out_cnt[0]; b_rd = rd_cnt[0];
        while (c < 120 && (sent < 32 || out_cnt[0] - b_out < 32)) begin
            in_valid[0] = (sent < 32);
            din[0] = 8'(sent);
            #1;
            if (in_valid[0] && !in_ready[0]) drops++;
            if (in_valid[0] && in_ready[0]) begin
                if (first_acc < 0) first_acc = c;
                sent++;
            end
            if (out_valid[0] && first_ov < 0) first_ov = c;
            tick();
            c++;
        end
        in_valid[0] = 1'b0;
        // counting the accept cycle as cycle 1, out_valid is first seen in cycle N+2
        chk("t1_first_out_latency", first_ov - first_acc, 17);
        chk("t1_in_ready_drops", drops, 0);
        chk("t1_out_count", out_cnt[0] - b_out, 32);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("t1_rd_addr[%0d]", i), rd_log[0][b_rd + i], perm[i % 16]);
            exp_d = 8'((i / 16) * 16) + 8'(perm[i % 16]);
            chk($sformatf("t1_data[%0d]", i), out_data[0][b_out + i], exp_d);
            chk($sformatf("t1_last[%0d]", i), out_lst[0][b_out + i], (i % 16) == 15);
        end

        // Interleaver output fed to the deinterleaver must restore 0..31
        c = 0; sent = 0; b_out1 = out_cnt[1];
        while (c < 120 && (sent < 32 || out_cnt[1] - b_out1 < 32)) begin
            in_valid[1] = (sent < 32);
            din[1] = (sent < 32) ? out_data[0][b_out + sent] : 8'd0;
            #1;
            if (in_valid[1] && in_ready[1]) sent++;
            tick();
            c++;
        end
        in_valid[1] = 1'b0;
        chk("t2_out_count", out_cnt[1] - b_out1, 32);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("t2_data[%0d]", i), out_data[1][b_out1 + i], i);
            chk($sformatf("t2_last[%0d]", i), out_lst[1][b_out1 + i], (i % 16) == 15);
        end

        // Backpressure: 40 offers with out_ready held low
        out_ready[0] = 1'b0; sent = 0;
        b_out = out_cnt[0]; b_rd = rd_cnt[0];
        for (int i = 0; i < 40; i++) begin
            in_valid[0] = 1'b1;
            din[0] = 8'(100 + sent);
            #1;
            if (in_ready[0]) sent++;
            if (i == 25) begin
                chk("t3_rd_addr_mid_stall", rd_addr[0], 4);
                chk("t3_out_valid_mid_stall", out_valid[0], 1);
            end
            tick();
        end
        in_valid[0] = 1'b0;
        #1;
        chk("t3_accepts", sent, 32);
        chk("t3_bank_full", bank_full[0], 2'b11);
        chk("t3_in_ready", in_ready[0], 0);
        chk("t3_out_valid_held", out_valid[0], 1);
        chk("t3_rd_en_stalled", rd_en[0], 0);
        chk("t3_rd_addr_held", rd_addr[0], 4);
        chk("t3_reads_issued", rd_cnt[0] - b_rd, 1);
        out_ready[0] = 1'b1;
        c = 0;
        while (c < 80 && out_cnt[0] - b_out < 32) begin
            tick();
            c++;
        end
        repeat (2) tick();
        chk("t3_out_count", out_cnt[0] - b_out, 32);
        for (int i = 0; i < 32; i++) begin
            exp_d = 8'(100 + (i / 16) * 16) + 8'(perm[i % 16]);
            chk($sformatf("t3_data[%0d]", i), out_data[0][b_out + i], exp_d);
        end

        // Flush with nothing written is ignored
        b_wr = wr_cnt;
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        repeat (4) tick();
        #1;
        chk("t4_flush_j0_writes", wr_cnt - b_wr, 0);
        chk("t4_flush_j0_ready", in_ready[0], 1);

        // 5 symbols then flush: 11 zero-padding writes, second flush inside padding ignored
        b_wr = wr_cnt; b_out = out_cnt[0];
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            din[0] = 8'(200 + i);
            tick();
        end
        in_valid[0] = 1'b0;
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        #1;
        chk("t4_pad_in_ready", in_ready[0], 0);
        chk("t4_pad_wr_en", wr_en[0], 1);
        chk("t4_pad_wr_zero", wr_zero[0], 1);
        tick(); tick();
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        c = 0;
        while (c < 60 && out_cnt[0] - b_out < 16) begin
            tick();
            c++;
        end
        repeat (3) tick();
        chk("t4_write_count", wr_cnt - b_wr, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4_wr_addr[%0d]", i), wr_log[b_wr + i], i);
            chk($sformatf("t4_wr_zero[%0d]", i), wz_log[b_wr + i], i >= 5);
        end
        chk("t4_out_count", out_cnt[0] - b_out, 16);
        for (int i = 0; i < 16; i++) begin
            exp_d = (perm[i] < 5) ? 8'(200 + 32'(perm[i])) : 8'd0;
            chk($sformatf("t4_data[%0d]", i), out_data[0][b_out + i], exp_d);
            chk($sformatf("t4_last[%0d]", i), out_lst[0][b_out + i], i == 15);
        end

        // Flush coincident with the 16th write is ignored
        b_wr = wr_cnt; b_out = out_cnt[0];
        for (int i = 0; i < 16; i++) begin
            in_valid[0] = 1'b1;
            din[0] = 8'(50 + i);
            flush[0] = (i == 15);
            tick();
        end
        in_valid[0] = 1'b0;
        flush[0] = 1'b0;
        repeat (3) tick();
        #1;
        chk("t6_write_count", wr_cnt - b_wr, 16);
        chk("t6_no_pad_wr_en", wr_en[0], 0);
        chk("t6_in_ready", in_ready[0], 1);
        c = 0;
        while (c < 60 && out_cnt[0] - b_out < 16) begin
            tick();
            c++;
        end
        repeat (2) tick();
        chk("t6_out_count", out_cnt[0] - b_out, 16);
        chk("t6_first_data", out_data[0][b_out], 50);
        chk("t6_last_data", out_data[0][b_out + 15], 65);

        // Asynchronous reset while reading k=7 and writing the other bank
        b_rd = rd_cnt[0]; sent = 0; c = 0;
        while (c < 60 && rd_cnt[0] - b_rd < 7) begin
            in_valid[0] = 1'b1;
            din[0] = 8'(sent);
            #1;
            if (in_ready[0]) sent++;
            tick();
            c++;
        end
        in_valid[0] = 1'b0;
        #1;
        chk("t5_pre_wr_bank", wr_bank[0], 1);
        chk("t5_pre_wr_addr", wr_addr[0], 7);
        chk("t5_pre_out_valid", out_valid[0], 1);
        rst = 1'b0;
        #1;
        chk("t5_reset_outputs", {in_ready[0], wr_en[0], wr_bank[0], wr_addr[0], wr_zero[0], rd_en[0],
            rd_bank[0], rd_addr[0], out_valid[0], out_last[0], bank_full[0]}, 0);
        #3;
        rst = 1'b1;
        tick(); tick();
        in_valid[0] = 1'b1;
        din[0] = 8'd77;
        #1;
        chk("t5_new_wr_en", wr_en[0], 1);
        chk("t5_new_wr_addr", wr_addr[0], 0);
        chk("t5_new_wr_bank", wr_bank[0], 0);
        tick();
        in_valid[0] = 1'b0;
        ovs = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (out_valid[0]) ovs++;
            tick();
        end
        chk("t5_no_stale_out_valid", ovs, 0);
        chk("t5_bank_full_after", bank_full[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
